// File: rtl/regfile_arbiter_pkg.sv
// Shared register-file definitions: data width, write-command encodings and
// special-function register addresses.
package regfile_arbiter_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic [2:0] WCMD_NONE        = 3'b000;
  localparam logic [2:0] WCMD_STATUS      = 3'b001;
  localparam logic [2:0] WCMD_FILE        = 3'b010;
  localparam logic [2:0] WCMD_FILE_STATUS = 3'b011;
  localparam logic [2:0] WCMD_FSR         = 3'b100;

  localparam logic [4:0] ADDR_INDF   = 5'h00;
  localparam logic [4:0] ADDR_TMR0   = 5'h01;
  localparam logic [4:0] ADDR_PCL    = 5'h02;
  localparam logic [4:0] ADDR_STATUS = 5'h03;
  localparam logic [4:0] ADDR_FSR    = 5'h04;

endpackage

// File: rtl/regfile_arbiter_if.sv
// Bus bundle between core, debug port and register file for regfile_arbiter.
// slave = arbiter side, master = environment side.
interface regfile_arbiter_if;
  import regfile_arbiter_pkg::*;

  logic                  coreValid;
  logic [2:0]            coreCmd;
  logic [4:0]            coreAddr;
  logic [DATA_WIDTH-1:0] coreData;
  logic                  coreStall;

  logic                  dbgReq;
  logic                  dbgWe;
  logic [4:0]            dbgAddr;
  logic [DATA_WIDTH-1:0] dbgWData;
  logic                  dbgAck;
  logic [DATA_WIDTH-1:0] dbgRData;

  logic [2:0]            rfWriteCommand;
  logic [4:0]            rfFileAddr;
  logic [DATA_WIDTH-1:0] rfWriteData;
  logic [DATA_WIDTH-1:0] rfReadData;

  modport slave (
    input  coreValid, coreCmd, coreAddr, coreData,
    input  dbgReq, dbgWe, dbgAddr, dbgWData,
    input  rfReadData,
    output coreStall, dbgAck, dbgRData,
    output rfWriteCommand, rfFileAddr, rfWriteData
  );

  modport master (
    output coreValid, coreCmd, coreAddr, coreData,
    output dbgReq, dbgWe, dbgAddr, dbgWData,
    output rfReadData,
    input  coreStall, dbgAck, dbgRData,
    input  rfWriteCommand, rfFileAddr, rfWriteData
  );

endinterface

// File: rtl/regfile_arbiter.sv
// Arbitrates the register-file write port between the core and a debug port.
// Define ARB_FAIR_EN to force a debug grant after STARVE_LIMIT core-held cycles.
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  regfile_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PEND, ACK} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [4:0]            addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  grant;
  logic                  force_grant;

`ifdef ARB_FAIR_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;

  // Counts only while waiting in PEND; any grant (and hence leaving PEND) clears it.
  always_comb begin
    starve_d = '0;
    if (state_q == PEND && !grant && bus.coreValid)
      starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end

  assign force_grant = (starve_q == LIMIT);
`else
  assign force_grant = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dbgReq) begin
          we_d    = bus.dbgWe;
          addr_d  = bus.dbgAddr;
          wdata_d = bus.dbgWData;
          state_d = PEND;
        end
      end
      PEND: begin
        grant = !bus.coreValid || force_grant;
        if (grant) begin
          state_d = ACK;
          if (!we_q) rdata_d = bus.rfReadData;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Debug only ever issues a plain file write or no write at all.
  always_comb begin
    bus.coreStall      = grant && bus.coreValid;
    bus.dbgAck         = (state_q == ACK);
    bus.dbgRData       = rdata_q;
    bus.rfWriteCommand = WCMD_NONE;
    bus.rfFileAddr     = '0;
    bus.rfWriteData    = '0;
    if (grant) begin
      bus.rfWriteCommand = we_q ? WCMD_FILE : WCMD_NONE;
      bus.rfFileAddr     = addr_q;
      bus.rfWriteData    = wdata_q;
    end else if (bus.coreValid) begin
      bus.rfWriteCommand = bus.coreCmd;
      bus.rfFileAddr     = bus.coreAddr;
      bus.rfWriteData    = bus.coreData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
